// File: rtl/lab62soc_irq_aggregator_if.sv
// lab62soc_irq_aggregator_if
//
// Purpose: Avalon-MM slave bus bundle for the lab62soc interrupt aggregator.
//          Uses the interval timer's slave conventions: word addressing,
//          active-low write strobe, registered readdata.
//
// Signals:
//   address     3   word address
//   chipselect  1   slave select
//   write_n     1   active-low write strobe
//   writedata  16   write data
//   readdata   16   registered read data (driven by the slave)
//
// Modports:
//   master - drives address/chipselect/write_n/writedata, receives readdata
//   slave  - receives address/chipselect/write_n/writedata, drives readdata
interface lab62soc_irq_aggregator_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/lab62soc_irq_aggregator.sv
// lab62soc_irq_aggregator
//
// Purpose: Latches up to 16 interrupt sources into a pending register,
//          applies a software mask and a per-source edge/level mode, and
//          presents a registered irq_out plus the index of the
//          lowest-numbered active source to the CPU.
//
// Parameters:
//   NUM_IRQ   number of interrupt sources, 1..16 (bits above read 0)
//
// Ports:
//   clk       single clock
//   reset     synchronous active-high reset
//   bus       Avalon-MM slave (lab62soc_irq_aggregator_if.slave)
//   irq_in    interrupt source lines, synchronous to clk (bit 0 = timer)
//   irq_out   registered OR of the active sources
//   irq_id    registered index of the lowest active source, 0 when none
//
// Register map (word addresses):
//   0 PENDING  read pending, write-1-to-clear (edge-mode bits only)
//   1 MASK     read/write
//   2 EDGE_SEL read/write, 1 = edge mode
//   3 ACTIVE   read-only, pending & mask
//   4 HIGHEST  read-only, {any_active, 11'b0, id[3:0]}
//   5 FORCE    write-only when LAB62SOC_IRQ_AGG_FORCE_EN is defined,
//              unmapped otherwise; always reads 0
//
// Optional feature macro: LAB62SOC_IRQ_AGG_FORCE_EN
module lab62soc_irq_aggregator #(
   parameter int NUM_IRQ = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   lab62soc_irq_aggregator_if.slave   bus,
   input  logic [NUM_IRQ-1:0]         irq_in,
   output logic                       irq_out,
   output logic [3:0]                 irq_id
);

   // All internal vectors are kept 16 bits wide; bits at or above NUM_IRQ
   // are forced to zero by VALID so they read 0 and ignore writes.
   localparam logic [15:0] VALID = 16'((32'd1 << NUM_IRQ) - 32'd1);

   logic [15:0] irq_ext;
   logic [15:0] irq_q;
   logic [15:0] pending;
   logic [15:0] pending_nxt;
   logic [15:0] mask_r;
   logic [15:0] edge_sel;
   logic [15:0] active;
   logic [15:0] rise;
   logic [15:0] w1c;
   logic [15:0] set_bits;
   logic [15:0] rd_mux;
   logic [3:0]  id_c;
   logic        wr_stb;

   // Widen the source lines to the full register width.
   always_comb begin
      irq_ext = '0;
      irq_ext[NUM_IRQ-1:0] = irq_in;
   end

   // Decode the write strobe and form the per-bit set/clear requests.
   // In edge mode a set beats a simultaneous W1C, so set_bits is OR-ed in
   // after the clear has been applied.
   always_comb begin
      wr_stb = bus.chipselect && !bus.write_n;
      rise   = irq_ext & ~irq_q;
      w1c    = (wr_stb && bus.address == 3'd0) ? (bus.writedata & VALID) : 16'h0000;
`ifdef LAB62SOC_IRQ_AGG_FORCE_EN
      set_bits = rise | ((wr_stb && bus.address == 3'd5) ? (bus.writedata & edge_sel) : 16'h0000);
`else
      set_bits = rise;
`endif
      pending_nxt = (edge_sel & (set_bits | (pending & ~w1c))) | (~edge_sel & irq_ext);
      active      = pending & mask_r;
   end

   // Lowest-numbered active source wins; scanning downward lets the
   // lowest set bit overwrite any higher one.
   always_comb begin
      id_c = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (active[i]) begin
            id_c = 4'(i);
         end
      end
   end

   // Read mux, registered below every cycle regardless of chipselect.
   always_comb begin
      rd_mux = 16'h0000;
      case (bus.address)
         3'd0:    rd_mux = pending;
         3'd1:    rd_mux = mask_r;
         3'd2:    rd_mux = edge_sel;
         3'd3:    rd_mux = active;
         3'd4:    rd_mux = {|active, 11'b0, id_c};
         default: rd_mux = 16'h0000;
      endcase
   end

   // State registers. Reset wins over any concurrent bus write.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q        <= '0;
         pending      <= '0;
         mask_r       <= '0;
         edge_sel     <= '0;
         irq_out      <= 1'b0;
         irq_id       <= 4'd0;
         bus.readdata <= '0;
      end else begin
         irq_q        <= irq_ext;
         pending      <= pending_nxt;
         irq_out      <= |active;
         irq_id       <= id_c;
         bus.readdata <= rd_mux;
         if (wr_stb && bus.address == 3'd1) begin
            mask_r <= bus.writedata & VALID;
         end
         if (wr_stb && bus.address == 3'd2) begin
            edge_sel <= bus.writedata & VALID;
         end
      end
   end

endmodule

// File: tb/tb_lab62soc_irq_aggregator.sv
// tb_lab62soc_irq_aggregator
//
// Purpose: Self-checking bench for lab62soc_irq_aggregator. Each cycle the
//          stimulus side predicts the registered outputs (irq_out, irq_id,
//          readdata) from a behavioural model and pushes them into a queue;
//          an independent monitor pops one entry per clock edge and compares.
module tb_lab62soc_irq_aggregator;

   localparam int          NUM_IRQ = 8;
   localparam logic [15:0] VALID   = 16'h00FF;

   logic               clk;
   logic               reset;
   logic [NUM_IRQ-1:0] irq_in;
   logic               irq_out;
   logic [3:0]         irq_id;

   lab62soc_irq_aggregator_if bus ();

   lab62soc_irq_aggregator #(.NUM_IRQ(NUM_IRQ)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .irq_in  (irq_in),
      .irq_out (irq_out),
      .irq_id  (irq_id)
   );

   typedef struct {
      logic        exp_out;
      logic [3:0]  exp_id;
      logic [15:0] exp_rd;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state: what software would see in each register.
   logic [15:0] m_pending;
   logic [15:0] m_mask;
   logic [15:0] m_edge;
   logic [15:0] m_prev;

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case anything stalls.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [3:0] lowestIndex(input logic [15:0] v);
      for (int i = 0; i < 16; i++) begin
         if (v[i]) return 4'(i);
      end
      return 4'd0;
   endfunction

   function automatic logic [15:0] modelRead(input logic [2:0] a);
      logic [15:0] act;
      act = m_pending & m_mask;
      case (a)
         3'd0:    return m_pending;
         3'd1:    return m_mask;
         3'd2:    return m_edge;
         3'd3:    return act;
         3'd4:    return {(act != 16'h0), 11'b0, lowestIndex(act)};
         default: return 16'h0000;
      endcase
   endfunction

   // Drive one cycle of inputs, predict the outputs registered at the next
   // edge, advance the model, then step to just after that edge.
   task automatic applyStimulus(input bit rst, input bit cs, input bit wr,
                                input logic [2:0] addr, input logic [15:0] wd,
                                input logic [15:0] irqv);
      exp_t        e;
      logic [15:0] act;
      logic [15:0] lvl;
      logic [15:0] rises;
      logic [15:0] clr;
      logic [15:0] frc;
      logic [15:0] nxt;
      reset          = rst;
      bus.chipselect = cs;
      bus.write_n    = ~wr;
      bus.address    = addr;
      bus.writedata  = wd;
      irq_in         = irqv[NUM_IRQ-1:0];
      if (rst) begin
         e = '{exp_out: 1'b0, exp_id: 4'd0, exp_rd: 16'h0000};
         m_pending = '0;
         m_mask    = '0;
         m_edge    = '0;
         m_prev    = '0;
      end else begin
         act       = m_pending & m_mask;
         e.exp_out = (act != 16'h0);
         e.exp_id  = lowestIndex(act);
         e.exp_rd  = modelRead(addr);
         lvl   = irqv & VALID;
         rises = lvl & ~m_prev;
         clr   = (cs && wr && addr == 3'd0) ? wd : 16'h0;
         frc   = 16'h0;
`ifdef LAB62SOC_IRQ_AGG_FORCE_EN
         frc   = (cs && wr && addr == 3'd5) ? (wd & m_edge) : 16'h0;
`endif
         nxt = 16'h0;
         for (int i = 0; i < NUM_IRQ; i++) begin
            if (m_edge[i]) nxt[i] = rises[i] | frc[i] | (m_pending[i] & ~clr[i]);
            else           nxt[i] = lvl[i];
         end
         if (cs && wr && addr == 3'd1) m_mask = wd & VALID;
         if (cs && wr && addr == 3'd2) m_edge = wd & VALID;
         m_pending = nxt;
         m_prev    = lvl;
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic doWrite(input logic [2:0] a, input logic [15:0] d, input logic [15:0] irqv);
      applyStimulus(1'b0, 1'b1, 1'b1, a, d, irqv);
   endtask

   task automatic doRead(input logic [2:0] a, input logic [15:0] irqv);
      applyStimulus(1'b0, 1'b1, 1'b0, a, 16'h0000, irqv);
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%04h expected 0x%04h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: one prediction per clock edge, sampled away from the edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput("irq_out",  {15'b0, irq_out}, {15'b0, e.exp_out});
            checkOutput("irq_id",   {12'b0, irq_id},  {12'b0, e.exp_id});
            checkOutput("readdata", bus.readdata,     e.exp_rd);
         end
      end
   end

   // Directed scenarios followed by randomized traffic.
   initial begin : stimulus
      logic [15:0] irqv;
      bit          rst;
      bit          cs;
      bit          wr;
      logic [2:0]  a;
      logic [15:0] d;

      // Reset with everything idle, then read PENDING.
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
      doRead(3'd0, 16'h0000);
      doRead(3'd0, 16'h0000);

      // Edge source 0: one-cycle pulse, observe, then W1C.
      doWrite(3'd2, 16'h0001, 16'h0000);
      doWrite(3'd1, 16'h0001, 16'h0000);
      doRead(3'd0, 16'h0001);
      doRead(3'd0, 16'h0000);
      doRead(3'd0, 16'h0000);
      doRead(3'd0, 16'h0000);
      doWrite(3'd0, 16'h0001, 16'h0000);
      doRead(3'd0, 16'h0000);
      doRead(3'd0, 16'h0000);

      // Level mode with two sources, then drop the higher-priority one.
      doWrite(3'd2, 16'h0000, 16'h0000);
      doWrite(3'd1, 16'h00FF, 16'h0000);
      doRead(3'd4, 16'h0024);
      doRead(3'd4, 16'h0024);
      doRead(3'd3, 16'h0024);
      doRead(3'd4, 16'h0020);
      doRead(3'd4, 16'h0020);
      doWrite(3'd0, 16'h00FF, 16'h0020);
      doRead(3'd0, 16'h0020);

      // Rising edge in the same cycle as W1C of that bit: set wins.
      doWrite(3'd2, 16'h0002, 16'h0000);
      doRead(3'd0, 16'h0000);
      doWrite(3'd0, 16'h0002, 16'h0002);
      doRead(3'd0, 16'h0002);
      doWrite(3'd0, 16'h0002, 16'h0002);
      doRead(3'd0, 16'h0002);

      // Masked pending sources, then unmask one.
      doWrite(3'd1, 16'h0000, 16'h0000);
      doWrite(3'd2, 16'h0003, 16'h0000);
      doRead(3'd0, 16'h0003);
      doRead(3'd3, 16'h0000);
      doRead(3'd3, 16'h0000);
      doWrite(3'd1, 16'h0002, 16'h0000);
      doRead(3'd4, 16'h0000);
      doRead(3'd4, 16'h0000);

      // FORCE write on an edge-mode source.
      doWrite(3'd0, 16'hFFFF, 16'h0000);
      doWrite(3'd2, 16'h0004, 16'h0000);
      doWrite(3'd1, 16'h0004, 16'h0000);
      doWrite(3'd5, 16'h0004, 16'h0000);
      doRead(3'd0, 16'h0000);
      doRead(3'd0, 16'h0000);
      doRead(3'd5, 16'h0000);

      // Reset mid-operation with a concurrent MASK write, source held high.
      applyStimulus(1'b1, 1'b1, 1'b1, 3'd1, 16'h00FF, 16'h0081);
      doWrite(3'd2, 16'h00FF, 16'h0081);
      doWrite(3'd1, 16'h00FF, 16'h0081);
      doRead(3'd4, 16'h0081);
      doRead(3'd4, 16'h0081);

      // Randomized traffic.
      irqv = 16'h0000;
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 3) == 0) irqv = irqv ^ 16'($urandom);
         rst = ($urandom_range(0, 99) == 0);
         cs  = ($urandom_range(0, 3) != 0);
         wr  = ($urandom_range(0, 1) == 1);
         a   = 3'($urandom_range(0, 7));
         d   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         applyStimulus(rst, cs, wr, a, d, irqv);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, irqv);

      // Let the monitor drain its last prediction.
      for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: %0d predictions left, required 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lab62soc_irq_aggregator.md
# lab62soc_irq_aggregator

Avalon-MM interrupt aggregator that sits directly downstream of the interval timer's `irq` output and of the other peripheral interrupt lines in the lab62soc system. It latches up to 16 interrupt sources into a pending register, applies a software mask and a per-source edge/level mode, and presents one registered `irq_out` plus the index of the highest-priority active source to the CPU interrupt input. Software services interrupts through a 16-bit register file that shares the timer's slave conventions: word addressing, `write_n`, and registered `readdata`.

## Interface
- `NUM_IRQ`, 8: number of interrupt sources. Legal range 1..16. Bits at or above `NUM_IRQ` read 0 and ignore writes.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `address` in 3: word address.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 16: write data.
- `readdata` out 16: registered read data.
- `irq_in` in NUM_IRQ: source lines, synchronous to `clk`. Bit 0 is the interval timer.
- `irq_out` out 1: registered OR of the active sources.
- `irq_id` out 4: registered index of the lowest-numbered active source. It is 0 when none is active.

## Operation
- A write strobe is `chipselect && !write_n`.
- `irq_q` registers `irq_in` every cycle. A rising edge is `irq_in & ~irq_q`.
- PENDING is updated per bit i each cycle:
  - Level mode (`EDGE_SEL[i]=0`): `pending[i] <= irq_in[i]`. Write-1-to-clear has no effect.
  - Edge mode (`EDGE_SEL[i]=1`): `pending[i]` is set on a rising edge. It is cleared by a W1C write to addr 0. If a set and a clear land in the same cycle, the set wins.
- `active = pending & MASK`.
- `irq_out` is registered `|active`.
- `irq_id` is registered as the lowest index i with `active[i]=1`.
- Register map. Unlisted addresses read 0 and ignore writes.
  - addr 0, PENDING: read returns pending; write is W1C.
  - addr 1, MASK: read/write. Writes never alter pending.
  - addr 2, EDGE_SEL: read/write.
  - addr 3, ACTIVE: read-only, returns `active`.
  - addr 4, HIGHEST: read-only, returns `{|active, 11'b0, id[3:0]}`, with the valid flag in bit 15.
  - addr 5, FORCE: see Configuration.
- Mode change edge→level: the bit follows `irq_in` from the next cycle.
- Mode change level→edge: the bit holds its current value until W1C or a new edge.
- `irq_q` resets to 0. An input already high when reset is released therefore registers as a rising edge on the first cycle.

## Timing
- Reset values are all 0: `readdata`, `irq_out`, `irq_id`, pending, MASK, EDGE_SEL and `irq_q`.
- `irq_in[i]` rises before clock edge E0:
  - `pending[i]=1` after E0.
  - `irq_out` and `irq_id` are valid after E1 (2-edge latency).
- W1C or MASK write at edge E0 → `irq_out` deasserts after E1.
- `readdata` is registered every cycle from the `address` mux, independent of `chipselect`. Data is valid on the cycle after the address is presented (1-cycle latency).
- A read of PENDING in the same cycle as a W1C returns the pre-write value.
- `reset` asserted mid-operation clears all state at that edge, regardless of any concurrent write.

## Configuration
- `LAB62SOC_IRQ_AGG_FORCE_EN` defined:
  - addr 5 FORCE is write-only. Written 1-bits set the matching `pending` bits for edge-mode sources only.
  - Force and W1C to the same bit cannot coincide, because they use different addresses.
  - FORCE reads return 0.
- Macro undefined: addr 5 behaves as unmapped, and no force logic is synthesised.

## Test plan
- Reset release with `irq_in=0`, MASK=0 → `irq_out=0`, `irq_id=0`, and a read of addr 0 returns 0x0000.
- EDGE_SEL=0x0001, MASK=0x0001, pulse `irq_in[0]` for 1 cycle:
  - → PENDING=0x0001 and `irq_out=1` two edges after the pulse.
  - Then W1C 0x0001 → `irq_out=0` one edge later.
- Level mode, MASK=0x00FF, `irq_in=0x0024` → `irq_id=2`, HIGHEST reads 0x8002, and ACTIVE reads 0x0024. Drop `irq_in[2]` → `irq_id=5`.
- Edge source: assert a rising edge in the same cycle as a W1C of that bit → PENDING bit stays 1.
- MASK=0 with PENDING=0x0003 → `irq_out=0` and ACTIVE reads 0. Write MASK=0x0002 → `irq_out=1` and `irq_id=1`.
- With `LAB62SOC_IRQ_AGG_FORCE_EN` defined, EDGE_SEL=0x0004, MASK=0x0004, write 0x0004 to addr 5 → PENDING=0x0004 and `irq_out=1`. Without the macro, the same write leaves PENDING=0x0000.
